// File: rtl/truth_table_scanner.sv
// Walks a 2-bit mux select through 00..11, holding each code HOLD cycles, and
// captures the mux output into a 4-bit truth table presented with valid/ack.
module truth_table_scanner #(
  parameter int HOLD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ack,
  input  logic       mux_in,
  output logic [1:0] sel,
  output logic [3:0] table_out,
  output logic       busy,
  output logic       valid
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= 2'b00;
      table_out <= 4'b0000;
      busy      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sel <= 2'b00;
          if (start) begin
            state     <= SCAN;
            cnt       <= '0;
            table_out <= 4'b0000;
            busy      <= 1'b1;
          end
        end
        SCAN: begin
          // sample on the last cycle of each hold window
          if (cnt == LAST) begin
            table_out[sel] <= mux_in;
            cnt            <= '0;
            if (sel == 2'b11) begin
              state <= DONE;
              sel   <= 2'b00;
              valid <= 1'b1;
            end else begin
              sel <= sel + 2'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (ack) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          sel   <= 2'b00;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Drives three scanners (HOLD = 2, 1, 4) against cells described by their truth tables.
module tb_truth_table_scanner;

  localparam int N = 3;
  localparam int HOLDS [N] = '{2, 1, 4};

  logic       clk;
  logic       rst_n;
  logic       start   [N];
  logic       ack     [N];
  logic       mux_in  [N];
  logic [3:0] fn      [N];
  logic [1:0] sel_o   [N];
  logic [3:0] tbl_o   [N];
  logic       busy_o  [N];
  logic       valid_o [N];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    // the cell under test: its output is its truth table indexed by {a,b}
    assign mux_in[g] = fn[g][sel_o[g]];
    truth_table_scanner #(.HOLD(HOLDS[g])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[g]),
      .ack       (ack[g]),
      .mux_in    (mux_in[g]),
      .sel       (sel_o[g]),
      .table_out (tbl_o[g]),
      .busy      (busy_o[g]),
      .valid     (valid_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input int d, input logic [1:0] s,
                          input logic [3:0] t, input logic b, input logic v);
    chk({tag, "_sel"},   8'(sel_o[d]),   8'(s));
    chk({tag, "_tbl"},   8'(tbl_o[d]),   8'(t));
    chk({tag, "_busy"},  8'(busy_o[d]),  8'(b));
    chk({tag, "_valid"}, 8'(valid_o[d]), 8'(v));
  endtask

  // One scan from the start edge until DONE; code k is presented cycles k*H..k*H+H-1
  // after the start edge and captured by the edge ending that window.
  task automatic scan(input int d, input logic [3:0] f, input bit keep);
    int h;
    logic [3:0] m;
    h = HOLDS[d];
    fn[d] = f;
    start[d] = 1'b1;
    tick();
    if (!keep) start[d] = 1'b0;
    for (int t = 0; t < 4 * h; t++) begin
      m = 4'((1 << (t / h)) - 1);
      chk_outs("scan", d, 2'(t / h), f & m, 1'b1, 1'b0);
      tick();
    end
    chk_outs("done", d, 2'b00, f, 1'b1, 1'b1);
  endtask

  task automatic drain(input int d, input logic [3:0] f, input int wait_n);
    for (int i = 0; i < wait_n; i++) begin
      tick();
      chk_outs("wait", d, 2'b00, f, 1'b1, 1'b1);
    end
    ack[d] = 1'b1;
    tick();
    ack[d] = 1'b0;
    chk_outs("acked", d, 2'b00, f, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] f;
    int d;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      start[i] = 1'b0;
      ack[i]   = 1'b0;
      fn[i]    = 4'b0000;
    end
    #2;
    for (int i = 0; i < N; i++) chk_outs("reset", i, 2'b00, 4'b0000, 1'b0, 1'b0);
    #10 rst_n = 1'b1;
    tick();
    tick();
    chk_outs("idle", 0, 2'b00, 4'b0000, 1'b0, 1'b0);

    // implication cell, then AND stub with a long ack delay
    scan(0, 4'b1011, 1'b0);
    drain(0, 4'b1011, 0);
    scan(0, 4'b1000, 1'b0);
    drain(0, 4'b1000, 5);

    // start held through the scan and the ack edge: only one scan
    scan(0, 4'b0111, 1'b1);
    drain(0, 4'b0111, 2);
    start[0] = 1'b0;
    tick();
    chk_outs("no_rescan", 0, 2'b00, 4'b0111, 1'b0, 1'b0);
    tick();
    chk_outs("no_rescan2", 0, 2'b00, 4'b0111, 1'b0, 1'b0);

    // HOLD = 1 with XOR stub
    scan(1, 4'b0110, 1'b0);
    drain(1, 4'b0110, 1);

    // random cells on all instances
    for (int i = 0; i < 9; i++) begin
      d = i % N;
      f = 4'($urandom);
      scan(d, f, 1'b0);
      drain(d, f, $urandom_range(0, 3));
    end

    // reset on the third sampling edge aborts the scan
    fn[0] = 4'b1111;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (5) tick();
    chk("pre_rst_tbl", 8'(tbl_o[0]), 8'h03);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk_outs("rst_mid", 0, 2'b00, 4'b0000, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_outs("post_rst", 0, 2'b00, 4'b0000, 1'b0, 1'b0);
    end

    // a fresh scan after reset still works
    scan(0, 4'b1001, 1'b0);
    drain(0, 4'b1001, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
